// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
//   Parametrised single-clock FIFO used on the UART TX/RX data paths, between
//   the APB register block and the shift logic.
//
//   Parameters:
//     WIDTH    - data word width (1..32)
//     DEPTH    - number of entries, power of two (4..4096)
//     AF_RESET - reset value of the almost-full threshold register
//     AE_RESET - reset value of the almost-empty threshold register
//     AW       - derived address width, log2(DEPTH)
//
//   Ports:
//     CLK, RESET_N         clock (rising edge) / async active-low reset
//     SCLR                 synchronous flush (thresholds are kept)
//     WE, DI               write request and data
//     RE, DO, DO_VALID     read request, registered data, one-cycle valid
//     LVL_WR               load AF_LEVEL / AE_LEVEL into threshold registers
//     AF_LEVEL, AE_LEVEL   almost-full / almost-empty thresholds
//     COUNT                occupancy, 0..DEPTH
//     FULL, EMPTY, AFULL, AEMPTY   registered status flags
//     OVERFLOW, UNDERFLOW  rejected write / rejected read indications
//     CLR_ERR              clears sticky error flags
//
//   Build option: define UART_FIFO_STICKY_ERR_EN to make OVERFLOW/UNDERFLOW
//   sticky until CLR_ERR, SCLR or reset. Without it they are one-cycle pulses
//   and CLR_ERR has no effect.
// ---------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 256,
  parameter int AF_RESET = DEPTH - 1,
  parameter int AE_RESET = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             SCLR,
  input  logic             WE,
  input  logic [WIDTH-1:0] DI,
  input  logic             RE,
  output logic [WIDTH-1:0] DO,
  output logic             DO_VALID,
  input  logic             LVL_WR,
  input  logic [AW:0]      AF_LEVEL,
  input  logic [AW:0]      AE_LEVEL,
  output logic [AW:0]      COUNT,
  output logic             FULL,
  output logic             EMPTY,
  output logic             AFULL,
  output logic             AEMPTY,
  output logic             OVERFLOW,
  output logic             UNDERFLOW,
  input  logic             CLR_ERR
);

  localparam logic [AW:0] DEPTH_V    = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_RESET_V = (AW+1)'(AF_RESET);
  localparam logic [AW:0] AE_RESET_V = (AW+1)'(AE_RESET);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW:0]      r_af_lvl;
  logic [AW:0]      r_ae_lvl;
  logic [WIDTH-1:0] r_do;
  logic             r_do_valid;
  logic             r_full;
  logic             r_empty;
  logic             r_afull;
  logic             r_aempty;
  logic             r_ovf;
  logic             r_udf;

  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_wr_rej;
  logic             w_rd_rej;
  logic [AW:0]      w_count_next;

  // A full FIFO can still take a write when a read frees a slot on the same
  // edge; an empty FIFO never forwards the incoming word to DO.
  assign w_rd_acc = RE & ~r_empty;
  assign w_wr_acc = WE & (~r_full | w_rd_acc);
  assign w_wr_rej = WE & ~w_wr_acc;
  assign w_rd_rej = RE & ~w_rd_acc;

  always_comb begin
    w_count_next = r_count;
    if (SCLR) begin
      w_count_next = '0;
    end else if (w_wr_acc && !w_rd_acc) begin
      w_count_next = r_count + 1'b1;
    end else if (w_rd_acc && !w_wr_acc) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge CLK) begin
    if (w_wr_acc && !SCLR) begin
      r_mem[r_wr_ptr] <= DI;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_af_lvl   <= AF_RESET_V;
      r_ae_lvl   <= AE_RESET_V;
      r_do       <= '0;
      r_do_valid <= 1'b0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_afull    <= 1'b0;
      r_aempty   <= 1'b1;
    end else begin
      // Flags use the count being loaded on this edge and the thresholds
      // held before it, so a new threshold takes effect one edge later.
      r_count  <= w_count_next;
      r_full   <= (w_count_next == DEPTH_V);
      r_empty  <= (w_count_next == '0);
      r_afull  <= (w_count_next >= r_af_lvl);
      r_aempty <= (w_count_next <= r_ae_lvl);
      if (LVL_WR) begin
        r_af_lvl <= AF_LEVEL;
        r_ae_lvl <= AE_LEVEL;
      end
      if (SCLR) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_do       <= '0;
        r_do_valid <= 1'b0;
      end else begin
        if (w_wr_acc) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_rd_acc) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
          r_do     <= r_mem[r_rd_ptr];
        end
        r_do_valid <= w_rd_acc;
      end
    end
  end

`ifdef UART_FIFO_STICKY_ERR_EN
  // Sticky errors: a new error in the same cycle as CLR_ERR keeps the flag set.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (SCLR) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_wr_rej) begin
        r_ovf <= 1'b1;
      end else if (CLR_ERR) begin
        r_ovf <= 1'b0;
      end
      if (w_rd_rej) begin
        r_udf <= 1'b1;
      end else if (CLR_ERR) begin
        r_udf <= 1'b0;
      end
    end
  end
`else
  // Pulse errors; CLR_ERR has nothing to clear in this build.
  logic w_unused_clr_err;
  assign w_unused_clr_err = CLR_ERR;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= w_wr_rej & ~SCLR;
      r_udf <= w_rd_rej & ~SCLR;
    end
  end
`endif

  assign DO        = r_do;
  assign DO_VALID  = r_do_valid;
  assign COUNT     = r_count;
  assign FULL      = r_full;
  assign EMPTY     = r_empty;
  assign AFULL     = r_afull;
  assign AEMPTY    = r_aempty;
  assign OVERFLOW  = r_ovf;
  assign UNDERFLOW = r_udf;

endmodule

// File: tb/tb_uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_sync_fifo
//   Self-checking bench for uart_sync_fifo (WIDTH=8, DEPTH=256). A queue based
//   reference model predicts every output after each clock edge; a short
//   vector table, directed sequences and a randomized run drive the design.
//   Honors UART_FIFO_STICKY_ERR_EN for the error-flag expectations.
// ---------------------------------------------------------------------------
module tb_uart_sync_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic             CLK      = 1'b0;
  logic             RESET_N  = 1'b0;
  logic             SCLR     = 1'b0;
  logic             WE       = 1'b0;
  logic [WIDTH-1:0] DI       = '0;
  logic             RE       = 1'b0;
  logic             LVL_WR   = 1'b0;
  logic [AW:0]      AF_LEVEL = '0;
  logic [AW:0]      AE_LEVEL = '0;
  logic             CLR_ERR  = 1'b0;
  logic [WIDTH-1:0] DO;
  logic             DO_VALID;
  logic [AW:0]      COUNT;
  logic             FULL, EMPTY, AFULL, AEMPTY, OVERFLOW, UNDERFLOW;

  always #5 CLK = ~CLK;

  uart_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .SCLR(SCLR), .WE(WE), .DI(DI), .RE(RE),
    .DO(DO), .DO_VALID(DO_VALID), .LVL_WR(LVL_WR), .AF_LEVEL(AF_LEVEL),
    .AE_LEVEL(AE_LEVEL), .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY),
    .AFULL(AFULL), .AEMPTY(AEMPTY), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW),
    .CLR_ERR(CLR_ERR)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  string g_tag = "init";

  // Reference model state
  logic [7:0] m_q[$];
  int         m_af, m_ae;
  logic [7:0] m_do;
  bit         m_dv, m_ovf, m_udf, m_full, m_empty, m_afull, m_aempty;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL [%s] %s: actual=%0h required=%0h", g_tag, name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_af = DEPTH - 1;
    m_ae = 1;
    m_do = '0;
    m_dv = 0; m_ovf = 0; m_udf = 0;
    m_full = 0; m_empty = 1; m_afull = 0; m_aempty = 1;
  endtask

  task automatic check_all();
    chk("COUNT", 32'(COUNT), 32'(m_q.size()));
    chk("EMPTY", 32'(EMPTY), 32'(m_empty));
    chk("FULL", 32'(FULL), 32'(m_full));
    chk("AFULL", 32'(AFULL), 32'(m_afull));
    chk("AEMPTY", 32'(AEMPTY), 32'(m_aempty));
    chk("DO", 32'(DO), 32'(m_do));
    chk("DO_VALID", 32'(DO_VALID), 32'(m_dv));
    chk("OVERFLOW", 32'(OVERFLOW), 32'(m_ovf));
    chk("UNDERFLOW", 32'(UNDERFLOW), 32'(m_udf));
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic cyc(input bit we, input bit [7:0] di, input bit re,
                     input bit sclr = 1'b0, input bit lvl = 1'b0,
                     input int af = 0, input int ae = 0, input bit clr = 1'b0);
    int sz;
    bit rd_ok, wr_ok, ovf_set, udf_set;
    WE = we; DI = di; RE = re; SCLR = sclr; LVL_WR = lvl;
    AF_LEVEL = 9'(af); AE_LEVEL = 9'(ae); CLR_ERR = clr;
    @(posedge CLK);
    #1;
    sz      = m_q.size();
    rd_ok   = re && (sz > 0);
    wr_ok   = we && ((sz < DEPTH) || rd_ok);
    ovf_set = we && !wr_ok;
    udf_set = re && !rd_ok;
    if (sclr) begin
      m_q.delete();
      m_do = '0; m_dv = 0; m_ovf = 0; m_udf = 0;
    end else begin
      m_dv = rd_ok;
      if (rd_ok) m_do = m_q.pop_front();
      if (wr_ok) m_q.push_back(di);
`ifdef UART_FIFO_STICKY_ERR_EN
      m_ovf = ovf_set || (m_ovf && !clr);
      m_udf = udf_set || (m_udf && !clr);
`else
      m_ovf = ovf_set;
      m_udf = udf_set;
`endif
    end
    sz       = m_q.size();
    m_full   = (sz == DEPTH);
    m_empty  = (sz == 0);
    m_afull  = (sz >= m_af);
    m_aempty = (sz <= m_ae);
    if (lvl) begin
      m_af = af;
      m_ae = ae;
    end
    check_all();
  endtask

  typedef struct {
    bit         we;
    bit         re;
    logic [7:0] di;
    int         cnt;
    logic [7:0] dout;
    bit         dv;
    bit         emp;
    bit         aemp;
    bit         udf;
    bit         udf_st;
  } vec_t;

  vec_t vt[10];

  initial begin
    int p_we;
    bit r_we, r_re, r_sclr, r_lvl, r_clr;

    //        we re di     cnt do     dv emp aemp udf udf_st
    vt[0] = '{1, 0, 8'h11, 1, 8'h00, 0, 0, 1, 0, 0};
    vt[1] = '{1, 0, 8'h22, 2, 8'h00, 0, 0, 0, 0, 0};
    vt[2] = '{0, 1, 8'h00, 1, 8'h11, 1, 0, 1, 0, 0};
    vt[3] = '{0, 0, 8'h00, 1, 8'h11, 0, 0, 1, 0, 0};
    vt[4] = '{1, 1, 8'h33, 1, 8'h22, 1, 0, 1, 0, 0};
    vt[5] = '{0, 1, 8'h00, 0, 8'h33, 1, 1, 1, 0, 0};
    vt[6] = '{0, 1, 8'h00, 0, 8'h33, 0, 1, 1, 1, 1};
    vt[7] = '{1, 1, 8'hA5, 1, 8'h33, 0, 0, 1, 1, 1};
    vt[8] = '{0, 1, 8'h00, 0, 8'hA5, 1, 1, 1, 0, 1};
    vt[9] = '{0, 0, 8'h00, 0, 8'hA5, 0, 1, 1, 0, 1};

    // Reset values while RESET_N is held low
    model_reset();
    #12;
    g_tag = "reset";
    check_all();
    RESET_N = 1'b1;

    // Vector table
    for (int i = 0; i < 10; i++) begin
      g_tag = $sformatf("vec%0d", i);
      cyc(vt[i].we, vt[i].di, vt[i].re);
      chk("tbl.COUNT", 32'(COUNT), 32'(vt[i].cnt));
      chk("tbl.DO", 32'(DO), 32'(vt[i].dout));
      chk("tbl.DO_VALID", 32'(DO_VALID), 32'(vt[i].dv));
      chk("tbl.EMPTY", 32'(EMPTY), 32'(vt[i].emp));
      chk("tbl.AEMPTY", 32'(AEMPTY), 32'(vt[i].aemp));
`ifdef UART_FIFO_STICKY_ERR_EN
      chk("tbl.UNDERFLOW", 32'(UNDERFLOW), 32'(vt[i].udf_st));
`else
      chk("tbl.UNDERFLOW", 32'(UNDERFLOW), 32'(vt[i].udf));
`endif
    end
    g_tag = "clr_err";
    cyc(0, 8'h00, 0, 0, 0, 0, 0, 1);
    chk("UNDERFLOW.cleared", 32'(UNDERFLOW), 32'd0);

    // Fill 0x00..0xFF, then overflow
    g_tag = "fill";
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 8'(i), 0);
      if (i == 254) begin
        chk("AFULL@255", 32'(AFULL), 32'd1);
        chk("FULL@255", 32'(FULL), 32'd0);
      end
      if (i == 255) begin
        chk("FULL@256", 32'(FULL), 32'd1);
        chk("COUNT@256", 32'(COUNT), 32'd256);
      end
    end
    g_tag = "overflow";
    cyc(1, 8'hEE, 0);
    chk("OVERFLOW", 32'(OVERFLOW), 32'd1);
    chk("COUNT.ovf", 32'(COUNT), 32'd256);
`ifdef UART_FIFO_STICKY_ERR_EN
    repeat (10) cyc(0, 8'h00, 0);
    chk("OVERFLOW.sticky", 32'(OVERFLOW), 32'd1);
    cyc(0, 8'h00, 0, 0, 0, 0, 0, 1);
    chk("OVERFLOW.clr", 32'(OVERFLOW), 32'd0);
`else
    cyc(0, 8'h00, 0);
    chk("OVERFLOW.pulse", 32'(OVERFLOW), 32'd0);
`endif

    // Drain in order, then underflow
    g_tag = "drain";
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 8'h00, 1);
      chk("DO.order", 32'(DO), 32'(i));
      chk("DO_VALID.drain", 32'(DO_VALID), 32'd1);
    end
    chk("EMPTY.drained", 32'(EMPTY), 32'd1);
    g_tag = "underflow";
    cyc(0, 8'h00, 1);
    chk("UNDERFLOW", 32'(UNDERFLOW), 32'd1);
    chk("DO.hold", 32'(DO), 32'hFF);
    chk("DO_VALID.rej", 32'(DO_VALID), 32'd0);

    // Full FIFO streaming through pointer wrap
    g_tag = "stream";
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 0);
    for (int k = 0; k < 300; k++) cyc(1, 8'(k + 7), 1);
    chk("COUNT.stream", 32'(COUNT), 32'd256);
    chk("FULL.stream", 32'(FULL), 32'd1);
    for (int i = 0; i < DEPTH; i++) cyc(0, 8'h00, 1);

    // Programmable thresholds, then flush keeps them
    g_tag = "thresh";
    cyc(0, 8'h00, 0, 0, 1, 16, 4);
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 8'(i), 0);
      if (i == 4)  chk("AEMPTY@4", 32'(AEMPTY), 32'd1);
      if (i == 5)  chk("AEMPTY@5", 32'(AEMPTY), 32'd0);
      if (i == 15) chk("AFULL@15", 32'(AFULL), 32'd0);
      if (i == 16) chk("AFULL@16", 32'(AFULL), 32'd1);
    end
    g_tag = "sclr";
    cyc(1, 8'h77, 1, 1);
    chk("COUNT.sclr", 32'(COUNT), 32'd0);
    chk("EMPTY.sclr", 32'(EMPTY), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 8'(i + 100), 0);
      if (i == 4)  chk("AEMPTY.kept", 32'(AEMPTY), 32'd1);
      if (i == 16) chk("AFULL.kept", 32'(AFULL), 32'd1);
    end

    // Reset asserted mid-burst
    g_tag = "midreset";
    cyc(0, 8'h00, 1);
    WE = 1'b1; DI = 8'h3C; RE = 1'b1;
    #3;
    RESET_N = 1'b0;
    #1;
    chk("rst.COUNT", 32'(COUNT), 32'd0);
    chk("rst.EMPTY", 32'(EMPTY), 32'd1);
    chk("rst.FULL", 32'(FULL), 32'd0);
    chk("rst.AEMPTY", 32'(AEMPTY), 32'd1);
    chk("rst.AFULL", 32'(AFULL), 32'd0);
    chk("rst.DO", 32'(DO), 32'd0);
    chk("rst.DO_VALID", 32'(DO_VALID), 32'd0);
    chk("rst.OVERFLOW", 32'(OVERFLOW), 32'd0);
    chk("rst.UNDERFLOW", 32'(UNDERFLOW), 32'd0);
    model_reset();
    #1;
    RESET_N = 1'b1;
    cyc(1, 8'h01, 0);
    cyc(1, 8'h02, 0);
    cyc(0, 8'h00, 1);

    // Randomized traffic against the model
    g_tag = "random";
    p_we = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) p_we = int'($urandom_range(15, 85));
      r_we   = ($urandom_range(0, 99) < p_we);
      r_re   = ($urandom_range(0, 99) < (100 - p_we));
      r_sclr = ($urandom_range(0, 299) == 0);
      r_lvl  = !r_sclr && ($urandom_range(0, 79) == 0);
      r_clr  = ($urandom_range(0, 15) == 0);
      cyc(r_we, 8'($urandom), r_re, r_sclr, r_lvl,
          int'($urandom_range(0, DEPTH)), int'($urandom_range(0, DEPTH)), r_clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
